vx_ibuffer_issue_arb: RTL

//  Round-robin arbiter sharing one scalar dispatch port among the ISSUE_CNT instruction-buffer slices.

---
 rtl/vx_ibuffer_issue_arb.sv | 66 ++++++
 1 files changed

// File: rtl/vx_ibuffer_issue_arb.sv
// vx_ibuffer_issue_arb: round-robin grant of one of ISSUE_CNT ibuffer slices per cycle into a registered dispatch stage tagged with the slice index; define VX_IBUF_ARB_PERF_EN for perf_issue_cnt/perf_stall_cnt
module vx_ibuffer_issue_arb #(
  parameter int ISSUE_CNT = 4,
  parameter int DATAW     = 128,
  parameter int ISW_WIDTH = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ISSUE_CNT-1:0]       in_valid,
  input  logic [ISSUE_CNT*DATAW-1:0] in_data,
  output logic [ISSUE_CNT-1:0]       in_ready,
  output logic                       out_valid,
  output logic [DATAW-1:0]           out_data,
  output logic [ISW_WIDTH-1:0]       out_isw,
  input  logic                       out_ready
`ifdef VX_IBUF_ARB_PERF_EN
  ,
  output logic [31:0]                perf_issue_cnt,
  output logic [31:0]                perf_stall_cnt
`endif
);
  logic [DATAW-1:0] slices [ISSUE_CNT];
  logic [ISW_WIDTH-1:0] rr_ptr, winner, next_ptr, idx;
  logic can_load, fire;
  for (genvar i = 0; i < ISSUE_CNT; i++) begin : g_slice
    assign slices[i] = in_data[i*DATAW +: DATAW];
  end
  always_comb begin
    winner = rr_ptr;
    idx = rr_ptr;
    for (int k = ISSUE_CNT - 1; k >= 0; k--) begin
      idx = ISW_WIDTH'((int'(rr_ptr) + k) % ISSUE_CNT);
      winner = in_valid[idx] ? idx : winner;
    end
  end
  assign can_load = !out_valid || out_ready;
  assign fire     = reset && can_load && |in_valid;
  assign in_ready = fire ? ISSUE_CNT'(1) << winner : '0;
  assign next_ptr = (int'(winner) == ISSUE_CNT - 1) ? '0 : winner + 1'b1;
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_isw   <= '0;
      rr_ptr    <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= slices[winner];
      out_isw   <= winner;
      rr_ptr    <= next_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef VX_IBUF_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_issue_cnt <= perf_issue_cnt + 32'(out_valid && out_ready);
      perf_stall_cnt <= perf_stall_cnt + 32'(out_valid && !out_ready);
    end
  end
`endif
endmodule
